fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode-stage main controller.
- Owns the PC register, the next-PC mux and the IF/ID pipeline register.
- Consumes the controller's Branch_Jump / nPc_Sel decisions, plus the ID comparator result and forwarded rs, to redirect fetch.
- Implements single-delay-slot semantics: the instruction after a branch/jump always executes.

Parameters:
RESET_PC, 32'h0000_3000, PC value after reset; also the reset value of pc_d.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  from hazard unit; holds PC and IF/ID register
branch_jump  input  1  controller Branch_Jump for the instruction in ID
npc_sel  input  3  controller nPc_Sel: 0 beq, 1 j/jal, 2 jr, 3-7 sequential
cmp_true  input  1  ID comparator result (rs==rt for beq)
jr_target  input  32  forwarded rs value for jr
imem_addr  output  32  instruction memory address (= pc_f, combinational)
imem_rdata  input  32  instruction word at imem_addr, combinational read
instr_d  output  32  IF/ID instruction register
pc_d  output  32  IF/ID PC register
pc8_d  output  32  pc_d + 8, jal link value
valid_d  output  1  IF/ID holds a fetched instruction (0 = reset bubble)

Behaviour:
- Reset:
  - pc_f = RESET_PC.
  - instr_d = 32'h0 (sll $0 nop).
  - pc_d = RESET_PC, valid_d = 0.
  - Reset has priority over stall and redirect.
- imem_addr = pc_f with no latency; the fetch result is registered into IF/ID at the next edge.
- Redirect is qualified as redir = valid_d & branch_jump & ~stall.
- Next PC, when ~reset & ~stall:
  - redir & npc_sel==0 & cmp_true: pc_d + 4 + (sign_extend(instr_d[15:0]) << 2).
  - redir & npc_sel==0 & ~cmp_true: pc_f + 4.
  - redir & npc_sel==1: {pc_d[31:28], instr_d[25:0], 2'b00}.
  - redir & npc_sel==2: jr_target, unmodified; no alignment fixup.
  - otherwise, including npc_sel 3-7: pc_f + 4.
- stall=1:
  - pc_f, instr_d, pc_d and valid_d all hold.
  - No redirect is taken while stalled.
  - A branch held in ID redirects in the first cycle stall drops, using the then-current cmp_true/jr_target.
- IF/ID update when ~stall: instr_d <= imem_rdata, pc_d <= pc_f, valid_d <= 1.
- Delay slot: when a branch is in ID, the instruction at pc_f (= pc_d+4) is latched normally. A redirect never squashes IF.
- Arithmetic: all PC adds are 32-bit modulo 2^32. pc_f=32'hFFFF_FFFC advances to 32'h0. pc8_d is combinational, modulo 2^32.
- Target computation uses only instr_d and pc_d, never imem_rdata. Redirect latency is one cycle: the target appears on imem_addr the cycle after the branch is in ID.
- Stall and redir in the same cycle: stall wins. Same for a redirect asserted while valid_d=0: it is ignored.
- Reset mid-stall or mid-redirect: the next state is the reset state; pending redirects are discarded.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs fetch_cnt [31:0] and stall_cnt [31:0], both reset to 0.
  - fetch_cnt increments on each edge with ~reset & ~stall.
  - stall_cnt increments on each edge with ~reset & stall.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then 3 free-running cycles, imem returns addr^32'hA5A5_0000:
  - imem_addr: 3000, 3004, 3008, 300C.
  - After 1st edge: instr_d=A5A5_3000, pc_d=3000, valid_d=1, pc8_d=3008.
- beq taken:
  - Setup: instr_d=1000_0003, pc_d=3010, pc_f=3014, branch_jump=1, npc_sel=0, cmp_true=1.
  - Next edge: pc_f=3020, instr_d=word@3014 (delay slot).
  - Same with cmp_true=0: pc_f=3018.
- Negative offset beq (imm=FFFE) at pc_d=3010 -> pc_f=300C. j with instr_d=0800_0C00 at pc_d=3010 -> pc_f=0000_3000.
- jr:
  - npc_sel=2, jr_target=0000_4000 -> pc_f=4000.
  - The same jr held with stall=1 for 2 cycles -> pc_f, instr_d, pc_d unchanged; redirect to 4000 on the edge after stall drops.
- Wrap and priority:
  - pc_f=FFFF_FFFC, no stall -> pc_f=0, pc_d=FFFF_FFFC, pc8_d=0000_0004.
  - reset asserted with stall=1 and a pending taken beq -> pc_f=3000, valid_d=0, instr_d=0.
- With FETCH_PERF_CNT_EN: reset, 5 run cycles, 3 stall cycles -> fetch_cnt=5, stall_cnt=3. Preloaded FFFF_FFFF stays at FFFF_FFFF.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID register, with one delay slot.
// Optional FETCH_PERF_CNT_EN adds saturating fetch and stall counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_jump,
    input  logic [2:0]  npc_sel,
    input  logic        cmp_true,
    input  logic [31:0] jr_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt,
`endif
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc8_d,
    output logic        valid_d
);

    logic [31:0] pcF;
    logic [31:0] nextPc;
    logic [31:0] seqPc;
    logic [31:0] branchTarget;
    logic [31:0] jumpTarget;
    logic        redir;

    assign imem_addr    = pcF;
    assign pc8_d        = pc_d + 32'd8;
    assign seqPc        = pcF + 32'd4;
    assign branchTarget = pc_d + 32'd4 + {{14{instr_d[15]}}, instr_d[15:0], 2'b00};
    assign jumpTarget   = {pc_d[31:28], instr_d[25:0], 2'b00};

    // A reset bubble in ID carries no real branch, so it must never redirect.
    assign redir = valid_d & branch_jump & ~stall;

    always_comb begin
        nextPc = seqPc;
        if (redir) begin
            case (npc_sel)
                3'd0:    nextPc = cmp_true ? branchTarget : seqPc;
                3'd1:    nextPc = jumpTarget;
                3'd2:    nextPc = jr_target;
                default: nextPc = seqPc;
            endcase
        end
    end

    // The delay-slot instruction at pcF is always latched; redirects only steer the PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcF     <= RESET_PC;
            instr_d <= 32'h0;
            pc_d    <= RESET_PC;
            valid_d <= 1'b0;
        end else if (!stall) begin
            pcF     <= nextPc;
            instr_d <= imem_rdata;
            pc_d    <= pcF;
            valid_d <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt <= 32'h0;
            stall_cnt <= 32'h0;
        end else if (stall) begin
            if (stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
        end else begin
            if (fetch_cnt != 32'hFFFF_FFFF)
                fetch_cnt <= fetch_cnt + 32'd1;
        end
    end
`endif

endmodule
